// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } ctrl_state_t;

    // True when a Decode source operand actually reads the register that Execute writes.
    // x0 is hardwired to zero, so it can never create a dependency.
    function automatic logic reg_hit(
        input logic                  use_src,
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] dst
    );
        return use_src && (src == dst) && (dst != ZERO_REG);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance monitoring; it sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count one per cycle with inc asserted, holding once every bit is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: drives PC / IF-ID / ID-EX
// enables and flushes from branch, mul/div, load-use and fetch-wait events.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_is_muldiv,
    input  logic             ex_branch_taken,
    input  logic             imem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             ex_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // The RUN cycle that sees the mul/div is its first Execute cycle, so the busy
    // countdown starts two short of the full latency (one for RUN, one for the exit cycle).
    localparam int unsigned MD_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
    localparam logic [MD_W-1:0] MD_INIT = MD_W'(MD_LATENCY - 2);

    ctrl_state_t     state;
    ctrl_state_t     state_next;
    logic [MD_W-1:0] md_cnt;
    logic [MD_W-1:0] md_cnt_next;
    logic            load_use;
    logic            flush_inc;
    logic            stall_inc;

    // Load-use compare: a load in Execute whose result is read by the instruction in Decode.
    always_comb begin
        load_use = ex_is_load &&
                   (reg_hit(id_use_rs1, id_rs1, ex_rd) || reg_hit(id_use_rs2, id_rs2, ex_rd));
    end

    // State and mul/div countdown register; reset drops straight back to RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_next;
            md_cnt <= md_cnt_next;
        end
    end

    // Next-state and control outputs; RUN resolves events in branch > mul/div > load-use > fetch-wait order.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        ex_hold     = 1'b0;
        flush_inc   = 1'b0;
        state_next  = state;
        md_cnt_next = md_cnt;
        case (state)
            RUN: begin
                if (ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    flush_inc  = 1'b1;
                end else if (ex_is_muldiv) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    ex_hold     = 1'b1;
                    state_next  = MD_BUSY;
                    md_cnt_next = MD_INIT;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end else if (!imem_ready) begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                end
            end
            MD_BUSY: begin
                if (md_cnt != '0) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    ex_hold     = 1'b1;
                    md_cnt_next = md_cnt - MD_W'(1);
                end else begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Performance counter increment strobes.
    always_comb begin
        stall_inc = ~pc_en;
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MD_LATENCY=4, CNT_W=4 so saturation is reachable).
module tb_pipe_hazard_ctrl;

    localparam int unsigned CNT_W = 4;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       ld;
        logic       md;
        logic       br;
        logic       imem;
        logic       e_pc_en;
        logic       e_ifid_en;
        logic       e_ifid_flush;
        logic       e_idex_flush;
        logic       e_ex_hold;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_is_load;
    logic             ex_is_muldiv;
    logic             ex_branch_taken;
    logic             imem_ready;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             ex_hold;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int errors = 0;
    int checks = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    pipe_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_is_load      (ex_is_load),
        .ex_is_muldiv    (ex_is_muldiv),
        .ex_branch_taken (ex_branch_taken),
        .imem_ready      (imem_ready),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .ex_hold         (ex_hold),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mkv(
        input logic [4:0] rs1, input logic [4:0] rs2, input logic use1, input logic use2,
        input logic [4:0] rd, input logic ld, input logic md, input logic br, input logic imem,
        input logic pe, input logic ie, input logic ifl, input logic idf, input logic eh
    );
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2; v.rd = rd;
        v.ld = ld; v.md = md; v.br = br; v.imem = imem;
        v.e_pc_en = pe; v.e_ifid_en = ie; v.e_ifid_flush = ifl;
        v.e_idex_flush = idf; v.e_ex_hold = eh;
        return v;
    endfunction

    task automatic checkBit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0b expected %0b", name, got, exp);
        end
    endtask

    task automatic checkCount(input string name, input logic [CNT_W-1:0] got, input int exp);
        checks++;
        if (got !== CNT_W'(exp)) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic checkOutput(input vec_t v, input string name);
        checkBit({name, ".pc_en"},      pc_en,      v.e_pc_en);
        checkBit({name, ".ifid_en"},    ifid_en,    v.e_ifid_en);
        checkBit({name, ".ifid_flush"}, ifid_flush, v.e_ifid_flush);
        checkBit({name, ".idex_flush"}, idex_flush, v.e_idex_flush);
        checkBit({name, ".ex_hold"},    ex_hold,    v.e_ex_hold);
    endtask

    // Drive one vector for one full cycle, check outputs mid-cycle, update counter model.
    task automatic applyStimulus(input vec_t v, input string name);
        @(negedge clk);
        id_rs1          = v.rs1;
        id_rs2          = v.rs2;
        id_use_rs1      = v.use1;
        id_use_rs2      = v.use2;
        ex_rd           = v.rd;
        ex_is_load      = v.ld;
        ex_is_muldiv    = v.md;
        ex_branch_taken = v.br;
        imem_ready      = v.imem;
        #1;
        checkOutput(v, name);
        if (!v.e_pc_en && exp_stall < 15) exp_stall++;
        if (v.e_ifid_flush && v.e_idex_flush && exp_flush < 15) exp_flush++;
    endtask

    // Let the last driven cycle's edge land, then compare the counters to the model.
    task automatic checkCounters(input string name);
        @(posedge clk);
        #1;
        checkCount({name, ".stall_cnt"}, stall_cnt, exp_stall);
        checkCount({name, ".flush_cnt"}, flush_cnt, exp_flush);
    endtask

    vec_t tbl[10];
    vec_t idle;
    vec_t md_stall;
    vec_t md_done;
    vec_t md_busy_imem;
    vec_t md_done_imem;
    vec_t imem_wait;

    initial begin
        //                 rs1   rs2   u1 u2 rd    ld md br im   pe ie ifl idf eh
        idle         = mkv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1,   1, 1, 0,  0,  0);
        imem_wait    = mkv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0,   0, 1, 1,  0,  0);
        md_stall     = mkv(5'd0, 5'd0, 0, 0, 5'd3, 0, 1, 0, 1,   0, 0, 0,  0,  1);
        md_done      = mkv(5'd0, 5'd0, 0, 0, 5'd3, 0, 1, 0, 1,   1, 1, 0,  0,  0);
        md_busy_imem = mkv(5'd0, 5'd0, 0, 0, 5'd3, 0, 1, 0, 0,   0, 0, 0,  0,  1);
        md_done_imem = mkv(5'd0, 5'd0, 0, 0, 5'd3, 0, 1, 0, 0,   1, 1, 0,  0,  0);

        tbl[0] = idle;
        tbl[1] = mkv(5'd1, 5'd5, 0, 1, 5'd5, 1, 0, 0, 1,   0, 0, 0, 1, 0);
        tbl[2] = mkv(5'd7, 5'd2, 1, 1, 5'd7, 1, 0, 0, 1,   0, 0, 0, 1, 0);
        tbl[3] = mkv(5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 1,   1, 1, 0, 0, 0);
        tbl[4] = mkv(5'd1, 5'd5, 0, 0, 5'd5, 1, 0, 0, 1,   1, 1, 0, 0, 0);
        tbl[5] = mkv(5'd5, 5'd3, 0, 1, 5'd5, 1, 0, 0, 1,   1, 1, 0, 0, 0);
        tbl[6] = mkv(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0,   0, 1, 1, 0, 0);
        tbl[7] = mkv(5'd4, 5'd4, 1, 1, 5'd9, 0, 0, 1, 0,   1, 1, 1, 1, 0);
        tbl[8] = mkv(5'd9, 5'd2, 1, 0, 5'd9, 1, 0, 0, 0,   0, 0, 0, 1, 0);
        tbl[9] = mkv(5'd5, 5'd5, 1, 1, 5'd5, 0, 0, 0, 1,   1, 1, 0, 0, 0);

        // Reset with idle inputs: RUN outputs and cleared counters.
        rst_n = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0; ex_rd = '0;
        ex_is_load = 0; ex_is_muldiv = 0; ex_branch_taken = 0; imem_ready = 1;
        #12;
        checkOutput(idle, "reset");
        checkCount("reset.stall_cnt", stall_cnt, 0);
        checkCount("reset.flush_cnt", flush_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle RUN vectors.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i], $sformatf("vec%0d", i));
        end
        checkCounters("table");

        // Fetch wait for two consecutive cycles.
        applyStimulus(imem_wait, "imem_w0");
        applyStimulus(imem_wait, "imem_w1");
        checkCounters("imem2");

        // Back-to-back mul/div: stall 3, release, stall 3, release; fetch-wait ignored while busy.
        applyStimulus(md_stall,     "md0_c0");
        applyStimulus(md_busy_imem, "md0_c1");
        applyStimulus(md_stall,     "md0_c2");
        applyStimulus(md_done_imem, "md0_c3");
        applyStimulus(md_stall,     "md1_c0");
        applyStimulus(md_stall,     "md1_c1");
        applyStimulus(md_stall,     "md1_c2");
        applyStimulus(md_done,      "md1_c3");
        applyStimulus(idle,         "md_after");
        checkCounters("muldiv");

        // Reset in the second busy cycle aborts the stall immediately.
        applyStimulus(md_stall, "rst_md_c0");
        applyStimulus(md_stall, "rst_md_c1");
        @(negedge clk);
        ex_is_muldiv = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        checkBit("rst_mid.pc_en", pc_en, 1'b1);
        checkBit("rst_mid.ex_hold", ex_hold, 1'b0);
        checkCount("rst_mid.stall_cnt", stall_cnt, 0);
        checkCount("rst_mid.flush_cnt", flush_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(idle,      "post_rst_idle");
        applyStimulus(imem_wait, "post_rst_imem");
        checkCounters("post_rst");

        // Saturation: keep stalling well past 15 cycles.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(imem_wait, $sformatf("sat%0d", i));
        end
        checkCounters("saturate");
        applyStimulus(imem_wait, "sat_more");
        checkCounters("saturate_hold");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
